// File: rtl/vx_tensor_mac_seq_pkg.sv
// Shared types and layout helpers for the sequential tensor MAC tile engine.
// Offsets are in bits into the flattened A/B/C/D tile buses.
package vx_tensor_mac_seq_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_ACCW = 32;
  localparam int DEF_TAGW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic int a_off(input int i, input int k, input int kk, input int dw);
    return (i * kk + k) * dw;
  endfunction

  function automatic int b_off(input int k, input int j, input int nn, input int dw);
    return (k * nn + j) * dw;
  endfunction

  function automatic int c_off(input int i, input int j, input int nn, input int accw);
    return (i * nn + j) * accw;
  endfunction

endpackage

// File: rtl/vx_tensor_mac_seq_lane.sv
// One D[i][j] accumulator: load C or keep (chain) on accept, then one signed MAC per k-slice.
// Single-cycle update; no flow control of its own, driven entirely by the parent FSM.
module vx_tensor_mac_seq_lane
  import vx_tensor_mac_seq_pkg::*;
#(
  parameter int K    = 2,
  parameter int DW   = DEF_DW,
  parameter int ACCW = DEF_ACCW,
  parameter int KW   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              chain,
  input  logic              mac_en,
  input  logic [KW-1:0]     k_sel,
  input  logic [K*DW-1:0]   a_row,
  input  logic [K*DW-1:0]   b_col,
  input  logic [ACCW-1:0]   c_val,
  output logic [ACCW-1:0]   acc
);

  logic signed [DW-1:0]   a_op;
  logic signed [DW-1:0]   b_op;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  assign a_op     = a_row[int'(k_sel) * DW +: DW];
  assign b_op     = b_col[int'(k_sel) * DW +: DW];
  assign prod     = (2*DW)'(a_op) * (2*DW)'(b_op);
  // Size cast of a signed value sign-extends; the add below wraps mod 2^ACCW.
  assign prod_ext = ACCW'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= chain ? acc : c_val;
    end else if (mac_en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/vx_tensor_mac_seq.sv
// Tile MAC D = A*B + C (or + previous D when chained), one k-slice per cycle, K-cycle latency.
// valid/ready on both sides; DONE holds result until ready_out, retire and accept merge on one edge.
module vx_tensor_mac_seq
  import vx_tensor_mac_seq_pkg::*;
#(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int K    = 2,
  parameter int DW   = DEF_DW,
  parameter int ACCW = DEF_ACCW,
  parameter int TAGW = DEF_TAGW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic                chain_in,
  input  logic [M*K*DW-1:0]   a_tile,
  input  logic [K*N*DW-1:0]   b_tile,
  input  logic [M*N*ACCW-1:0] c_tile,
  input  logic [TAGW-1:0]     tag_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [M*N*ACCW-1:0] d_tile,
  output logic [TAGW-1:0]     tag_out
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;

  state_e              state;
  logic [KW-1:0]       k_q;
  logic [M*K*DW-1:0]   a_q;
  logic [K*N*DW-1:0]   b_q;
  logic [TAGW-1:0]     tag_q;
  logic                accept;

  assign ready_in  = (state == ST_IDLE) || ((state == ST_DONE) && ready_out);
  assign valid_out = (state == ST_DONE);
  assign tag_out   = tag_q;
  assign accept    = valid_in && ready_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      k_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (valid_in) state <= ST_BUSY;
        ST_BUSY: begin
          if (k_q == KW'(K - 1)) state <= ST_DONE;
          else                   k_q   <= k_q + 1'b1;
        end
        ST_DONE: if (ready_out) state <= valid_in ? ST_BUSY : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (accept) begin
        a_q   <= a_tile;
        b_q   <= b_tile;
        tag_q <= tag_in;
        k_q   <= '0;
      end
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [K*DW-1:0] b_col;
      // B columns are strided in the flat bus; gather them so the lane sees k-contiguous operands.
      for (genvar k = 0; k < K; k++) begin : g_k
        assign b_col[k*DW +: DW] = b_q[b_off(k, j, N, DW) +: DW];
      end

      vx_tensor_mac_seq_lane #(
        .K    (K),
        .DW   (DW),
        .ACCW (ACCW),
        .KW   (KW)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .chain  (chain_in),
        .mac_en (state == ST_BUSY),
        .k_sel  (k_q),
        .a_row  (a_q[a_off(i, 0, K, DW) +: K*DW]),
        .b_col  (b_col),
        .c_val  (c_tile[c_off(i, j, N, ACCW) +: ACCW]),
        .acc    (d_tile[c_off(i, j, N, ACCW) +: ACCW])
      );
    end
  end

endmodule

// File: tb/tb_vx_tensor_mac_seq.sv
// Scoreboard bench for vx_tensor_mac_seq: expected tiles queued at accept, compared at retire.
module tb_vx_tensor_mac_seq;

  localparam int M    = 4;
  localparam int N    = 4;
  localparam int K    = 2;
  localparam int DW   = 16;
  localparam int ACCW = 32;
  localparam int TAGW = 4;
  localparam int AW   = M*K*DW;
  localparam int BW   = K*N*DW;
  localparam int CW   = M*N*ACCW;

  logic            clk;
  logic            reset;
  logic            valid_in;
  logic            ready_in;
  logic            chain_in;
  logic [AW-1:0]   a_tile;
  logic [BW-1:0]   b_tile;
  logic [CW-1:0]   c_tile;
  logic [TAGW-1:0] tag_in;
  logic            valid_out;
  logic            ready_out;
  logic [CW-1:0]   d_tile;
  logic [TAGW-1:0] tag_out;

  vx_tensor_mac_seq #(
    .M(M), .N(N), .K(K), .DW(DW), .ACCW(ACCW), .TAGW(TAGW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .chain_in  (chain_in),
    .a_tile    (a_tile),
    .b_tile    (b_tile),
    .c_tile    (c_tile),
    .tag_in    (tag_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .d_tile    (d_tile),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]   d;
    logic [TAGW-1:0] tag;
    int              acc_cyc;
  } exp_t;

  exp_t            sb[$];
  logic [CW-1:0]   model_prev;
  int              cyc_n;
  int              first_vld;
  int              n_chk;
  int              n_err;

  logic            s_v, s_ch, s_ro;
  logic [AW-1:0]   s_a;
  logic [BW-1:0]   s_b;
  logic [CW-1:0]   s_c;
  logic [TAGW-1:0] s_tag;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                          input logic [CW-1:0] c, input logic ch,
                                          input logic [CW-1:0] prev);
    logic [CW-1:0]          d;
    logic signed [ACCW-1:0] s;
    longint                 p;
    d = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        s = ch ? prev[(i*N+j)*ACCW +: ACCW] : c[(i*N+j)*ACCW +: ACCW];
        for (int k = 0; k < K; k++) begin
          p = longint'($signed(a[(i*K+k)*DW +: DW])) * longint'($signed(b[(k*N+j)*DW +: DW]));
          s = s + p[ACCW-1:0];
        end
        d[(i*N+j)*ACCW +: ACCW] = s;
      end
    end
    return d;
  endfunction

  function automatic logic [AW-1:0] const_a(input int v);
    logic [AW-1:0] r;
    for (int e = 0; e < M*K; e++) r[e*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [BW-1:0] const_b(input int v);
    logic [BW-1:0] r;
    for (int e = 0; e < K*N; e++) r[e*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [CW-1:0] const_c(input int v);
    logic [CW-1:0] r;
    for (int e = 0; e < M*N; e++) r[e*ACCW +: ACCW] = ACCW'(v);
    return r;
  endfunction

  // One clock: drive shadow inputs at negedge, observe settled outputs 1 time unit later.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    valid_in  = s_v;
    chain_in  = s_ch;
    a_tile    = s_a;
    b_tile    = s_b;
    c_tile    = s_c;
    tag_in    = s_tag;
    ready_out = s_ro;
    #1;
    cyc_n++;
    if (valid_out) begin
      if (sb.size() == 0) begin
        chk("spurious_valid_out", valid_out, 1'b0);
      end else begin
        chk("d_tile", d_tile, sb[0].d);
        chk("tag_out", tag_out, sb[0].tag);
        if (first_vld < 0) first_vld = cyc_n;
        if (!ready_out) begin
          chk("stall_ready_in", ready_in, 1'b0);
        end else begin
          chk("latency", first_vld - sb[0].acc_cyc, K + 1);
          void'(sb.pop_front());
          first_vld = -1;
        end
      end
    end
    if (valid_in && ready_in) begin
      e.d       = model(a_tile, b_tile, c_tile, chain_in, model_prev);
      e.tag     = tag_in;
      e.acc_cyc = cyc_n;
      sb.push_back(e);
      model_prev = e.d;
    end
  endtask

  task automatic drain();
    s_v  = 1'b0;
    s_ro = 1'b1;
    for (int t = 0; t < 40 && sb.size() > 0; t++) tick();
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic rand_op();
    for (int w = 0; w < AW/32; w++) s_a[w*32 +: 32] = $urandom;
    for (int w = 0; w < BW/32; w++) s_b[w*32 +: 32] = $urandom;
    for (int w = 0; w < CW/32; w++) s_c[w*32 +: 32] = $urandom;
    s_tag = TAGW'($urandom);
    s_ch  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ta;
    logic [BW-1:0] tb;
    logic [CW-1:0] tc;
    n_chk = 0; n_err = 0; cyc_n = 0; first_vld = -1; model_prev = '0;
    s_v = 0; s_ch = 0; s_ro = 1; s_a = '0; s_b = '0; s_c = '0; s_tag = '0;
    valid_in = 0; chain_in = 0; a_tile = '0; b_tile = '0; c_tile = '0; tag_in = '0;
    ready_out = 1; reset = 1'b0;

    @(negedge clk); #1;
    chk("rst_ready_in", ready_in, 1'b1);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_d_tile", d_tile, '0);
    chk("rst_tag_out", tag_out, '0);
    reset = 1'b1;

    // Basic: 1*2*2 + 3 = 7 everywhere
    s_v = 1; s_ch = 0; s_a = const_a(1); s_b = const_b(2); s_c = const_c(3); s_tag = 4'h5;
    tick();
    drain();
    chk("basic_value", model_prev, const_c(7));

    // Signed product of two most-negative values wraps the accumulator
    ta = '0; ta[DW-1:0] = 16'h8000;
    tb = '0; tb[DW-1:0] = 16'h8000;
    tc = '0; tc[ACCW-1:0] = 32'h7FFF_FFFF;
    s_v = 1; s_ch = 0; s_a = ta; s_b = tb; s_c = tc; s_tag = 4'hA;
    tick();
    drain();
    tc[ACCW-1:0] = 32'hBFFF_FFFF;
    chk("wrap_value", model_prev, tc);

    // Chain: 7 + 1*1*2 = 9, C ignored
    s_v = 1; s_ch = 0; s_a = const_a(1); s_b = const_b(2); s_c = const_c(3); s_tag = 4'h1;
    tick();
    drain();
    s_v = 1; s_ch = 1; s_a = const_a(1); s_b = const_b(1); s_c = const_c('h55); s_tag = 4'h2;
    tick();
    drain();
    chk("chain_value", model_prev, const_c(9));

    // Backpressure in DONE, then retire and accept on the same edge
    s_v = 1; s_ch = 0; s_a = const_a(3); s_b = const_b(-2); s_c = const_c(100); s_tag = 4'h7;
    tick();
    s_v = 0; s_ro = 0;
    repeat (K + 6) tick();
    s_v = 1; s_ro = 1; s_ch = 1; s_a = const_a(-1); s_b = const_b(5); s_tag = 4'h8;
    tick();
    chk("b2b_ready_in", ready_in, 1'b1);
    drain();

    // Reset mid-operation aborts immediately; next chained op sees zero
    s_v = 1; s_ch = 0; s_a = const_a(4); s_b = const_b(4); s_c = const_c(9); s_tag = 4'hC;
    tick();
    s_v = 0;
    tick();
    #1 reset = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_ready_in", ready_in, 1'b1);
    chk("midrst_d_tile", d_tile, '0);
    chk("midrst_tag_out", tag_out, '0);
    sb.delete();
    first_vld = -1;
    model_prev = '0;
    tick();
    reset = 1'b1;
    s_v = 1; s_ch = 1; s_a = const_a(1); s_b = const_b(1); s_c = const_c(77); s_tag = 4'h3;
    tick();
    drain();
    chk("post_reset_chain", model_prev, const_c(2));

    // Random operands, random valid/chain/ready_out
    for (int n = 0; n < 400; n++) begin
      rand_op();
      s_v  = ($urandom_range(0, 3) != 0);
      s_ro = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vx_tensor_mac_seq.md
# VX_tensor_mac_seq

Parametrised, synthesizable successor to the fixed-latency HMMA model. It computes one tile product D = A·B + C (or D = A·B + D_prev in chained mode) on signed integer operands, one k-slice per cycle, with a full valid/ready handshake on both sides and a tagged result. It sits in the tensor-core execute path between the operand-collector dispatch and the writeback arbiter, one instance per octet.

## Interface
- M, 4, rows of A/C/D
- N, 4, columns of B/C/D
- K, 2, inner dimension; number of MAC cycles per operation (K ≥ 1)
- DW, 16, signed operand width of A and B elements
- ACCW, 32, signed width of C/D elements and accumulators (ACCW ≥ 2·DW)
- TAGW, `NW_WIDTH, width of the pass-through tag (warp id)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  operation request
- ready_in  out  1  operation accepted when valid_in && ready_in
- chain_in  in  1  0: accumulate onto c_tile; 1: accumulate onto held D from previous operation
- a_tile  in  M·K·DW  A, element [i][k] at bits ((i·K+k)·DW)+:DW
- b_tile  in  K·N·DW  B, element [k][j] at ((k·N+j)·DW)+:DW
- c_tile  in  M·N·ACCW  C, element [i][j] at ((i·N+j)·ACCW)+:ACCW
- tag_in  in  TAGW  tag carried with the operation
- valid_out  out  1  result valid
- ready_out  in  1  consumer accepts when valid_out && ready_out
- d_tile  out  M·N·ACCW  result, same layout as c_tile
- tag_out  out  TAGW  tag of the result

## Operation
- FSM states: IDLE, BUSY, DONE. Reset (reset low, async): state IDLE, k counter 0, accumulators 0, tag 0; outputs ready_in=1, valid_out=0, d_tile=0, tag_out=0.
- ready_in = (state==IDLE) || (state==DONE && ready_out).
- Accept edge: latch a_tile, b_tile, tag_in; acc[i][j] ← chain_in ? acc[i][j] : c_tile[i][j]; k←0; state→BUSY.
- BUSY edge: acc[i][j] ← acc[i][j] + sext(A[i][k]·B[k][j]) for all i,j; if k==K−1 → DONE, else k←k+1.
- DONE: valid_out=1, d_tile=acc, tag_out=latched tag, all stable until handshake. On ready_out: accept new op if valid_in (→BUSY), else → IDLE.
- IDLE: valid_out=0; d_tile keeps last result (needed by chain_in); tag_out keeps last tag.
- Arithmetic: DW×DW signed product (2·DW bits), sign-extended to ACCW, two's-complement add wrapping mod 2^ACCW; no saturation, no flags.
- chain_in in IDLE after reset chains onto 0.
- Simultaneous ready_out and valid_in in DONE: result retires and new op accepted on the same edge; no bubble.
- Inputs ignored when not accepting; valid_in may drop without accept (no obligation to hold).
- reset asserted mid-operation: immediate abort to reset state; in-flight result and tag discarded.

## Timing
- Latency: valid_out rises K cycles after the accept edge (K BUSY cycles).
- Throughput with ready_out tied high: one operation every K+1 cycles (accept, K BUSY edges, DONE→accept merges the retire/accept edge, so steady state is one op per K+1 cycles including DONE).
- ready_in, valid_out are pure functions of registered state and ready_out; no combinational path from valid_in to any output.
- Backpressure: DONE held indefinitely while ready_out=0; d_tile/tag_out unchanged.

## Structure
- Package VX_tensor_pkg: state enum (IDLE/BUSY/DONE), element index helper functions for the flattened layouts, ACCW/DW default constants.
- Sub-module VX_tensor_mac_lane (one per i,j): ACCW accumulator with load/chain/mac controls and K-way operand mux; top holds FSM, k counter, operand/tag registers.

## Test plan
- Basic: M=N=4,K=2, A all 1, B all 2, C all 3, chain_in=0 → after 2 cycles valid_out, every D element = 7, tag_out=tag_in.
- Signed/wrap: A[0][0]=−32768, B[0][0]=−32768, others 0, C[0][0]=0x7FFFFFFF → D[0][0]=0xBFFFFFFF (wrap), others 0.
- Chain: op1 as basic (D=7), op2 with chain_in=1, A all 1, B all 1, C=0x55 ignored → D all 9.
- Backpressure/back-to-back: ready_out low 5 cycles in DONE → d_tile stable, ready_in=0; then ready_out and valid_in high same cycle → retire and accept on one edge, next valid_out K cycles later.
- Reset mid-op: reset low during BUSY → valid_out=0, ready_in=1 immediately; next op with chain_in=1, A=B=1 → D all 2 (chained onto 0).
- K=1 and K=4 builds: random signed operands vs reference model, 1000 ops, random ready_out.
